reorder_buffer_mw: RTL and testbench

- Multi-issue successor to the single-wide reorder buffer.
- Allocates up to DISPATCH_WIDTH entries per cycle and accepts up to CDB_PORTS completions per cycle.
- Retires up to RETIRE_WIDTH in-order entries per cycle to the register map.
- A retiring taken branch selectively flushes younger entries instead of resetting the pointers.
- Sits between the dispatcher, the CDB, the register map and fetch redirect.

---
 rtl/reorder_buffer_mw.sv | 208 ++++++++++++++++++++
 tb/tb_reorder_buffer_mw.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_mw.sv
// Multi-issue reorder buffer: wide in-order allocate, multi-port CDB completion,
// wide in-order retire, and selective flush when a taken branch retires.
module reorder_buffer_mw #(
    parameter int  DATA_WIDTH     = 32,
    parameter int  ADDR_WIDTH     = 32,
    parameter int  ROB_DEPTH      = 64,
    parameter int  REG_ADDR_WIDTH = 5,
    parameter int  DISPATCH_WIDTH = 2,
    parameter int  RETIRE_WIDTH   = 2,
    parameter int  CDB_PORTS      = 2,
    localparam int TAG_WIDTH      = $clog2(ROB_DEPTH)
) (
    input  logic                                       clk,
    input  logic                                       n_rst,
    input  logic [DISPATCH_WIDTH-1:0]                  i_disp_valid,
    input  logic [DISPATCH_WIDTH-1:0]                  i_disp_rdy,
    input  logic [DISPATCH_WIDTH*DATA_WIDTH-1:0]       i_disp_data,
    input  logic [DISPATCH_WIDTH*REG_ADDR_WIDTH-1:0]   i_disp_rdest,
    output logic                                       o_disp_ready,
    output logic [DISPATCH_WIDTH*TAG_WIDTH-1:0]        o_disp_tag,
    input  logic [CDB_PORTS-1:0]                       i_cdb_en,
    input  logic [CDB_PORTS*TAG_WIDTH-1:0]             i_cdb_tag,
    input  logic [CDB_PORTS*DATA_WIDTH-1:0]            i_cdb_data,
    input  logic [CDB_PORTS*ADDR_WIDTH-1:0]            i_cdb_addr,
    input  logic [CDB_PORTS-1:0]                       i_cdb_branch,
    input  logic [2*DISPATCH_WIDTH*TAG_WIDTH-1:0]      i_lookup_tag,
    output logic [2*DISPATCH_WIDTH*DATA_WIDTH-1:0]     o_lookup_data,
    output logic [2*DISPATCH_WIDTH-1:0]                o_lookup_rdy,
    output logic [RETIRE_WIDTH-1:0]                    o_retire_en,
    output logic [RETIRE_WIDTH*REG_ADDR_WIDTH-1:0]     o_retire_rdest,
    output logic [RETIRE_WIDTH*DATA_WIDTH-1:0]         o_retire_data,
    output logic [RETIRE_WIDTH*TAG_WIDTH-1:0]          o_retire_tag,
    output logic                                       o_branch,
    output logic [ADDR_WIDTH-1:0]                      o_branch_addr,
    output logic [TAG_WIDTH:0]                         o_count
);

    localparam int PTR_WIDTH = TAG_WIDTH + 1;
    localparam int LOOKUPS   = 2 * DISPATCH_WIDTH;

    logic [PTR_WIDTH-1:0]      head;
    logic [PTR_WIDTH-1:0]      tail;
    logic [PTR_WIDTH-1:0]      count;
    logic [PTR_WIDTH-1:0]      alloc_cnt;
    logic [PTR_WIDTH-1:0]      retire_cnt;

    logic [ROB_DEPTH-1:0]      ent_valid;
    logic [ROB_DEPTH-1:0]      ent_rdy;
    logic [ROB_DEPTH-1:0]      ent_branch;
    logic [DATA_WIDTH-1:0]     ent_data  [ROB_DEPTH];
    logic [ADDR_WIDTH-1:0]     ent_addr  [ROB_DEPTH];
    logic [REG_ADDR_WIDTH-1:0] ent_rdest [ROB_DEPTH];

    logic [TAG_WIDTH-1:0]      disp_idx [DISPATCH_WIDTH];
    logic [TAG_WIDTH-1:0]      ret_idx  [RETIRE_WIDTH];
    logic [TAG_WIDTH-1:0]      cdb_idx  [CDB_PORTS];

    logic                      disp_fire;
    logic                      branch_hit;
    logic [ADDR_WIDTH-1:0]     branch_addr;
    logic [RETIRE_WIDTH-1:0]   retire_en;
    logic                      cdb_dup;

    always_comb begin
        for (int unsigned k = 0; k < DISPATCH_WIDTH; k++) begin
            disp_idx[k] = tail[TAG_WIDTH-1:0] + TAG_WIDTH'(k);
        end
        for (int unsigned j = 0; j < RETIRE_WIDTH; j++) begin
            ret_idx[j] = head[TAG_WIDTH-1:0] + TAG_WIDTH'(j);
        end
        for (int unsigned p = 0; p < CDB_PORTS; p++) begin
            cdb_idx[p] = i_cdb_tag[p*TAG_WIDTH +: TAG_WIDTH];
        end
    end

    // Dispatch readiness uses pre-retire occupancy, so a slot freed this cycle
    // is never reallocated in the same cycle.
    always_comb begin
        count        = tail - head;
        o_count      = count;
        o_disp_ready = ((ROB_DEPTH - int'(count)) >= DISPATCH_WIDTH) && !branch_hit;
        disp_fire    = o_disp_ready;
        alloc_cnt    = '0;
        for (int unsigned k = 0; k < DISPATCH_WIDTH; k++) begin
            alloc_cnt = alloc_cnt + PTR_WIDTH'(i_disp_valid[k]);
            o_disp_tag[k*TAG_WIDTH +: TAG_WIDTH] = disp_idx[k];
        end
    end

    // Retire walks from head and stops at the first entry that cannot go,
    // or immediately after a branch entry.
    always_comb begin
        logic blocked;
        blocked     = 1'b0;
        retire_en   = '0;
        retire_cnt  = '0;
        branch_hit  = 1'b0;
        branch_addr = '0;
        for (int unsigned j = 0; j < RETIRE_WIDTH; j++) begin
            o_retire_rdest[j*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] = ent_rdest[ret_idx[j]];
            o_retire_data[j*DATA_WIDTH +: DATA_WIDTH]          = ent_data[ret_idx[j]];
            o_retire_tag[j*TAG_WIDTH +: TAG_WIDTH]             = ret_idx[j];
            if (!blocked && ent_valid[ret_idx[j]] && ent_rdy[ret_idx[j]]) begin
                retire_en[j] = 1'b1;
                retire_cnt   = retire_cnt + PTR_WIDTH'(1);
                if (ent_branch[ret_idx[j]]) begin
                    branch_hit  = 1'b1;
                    branch_addr = ent_addr[ret_idx[j]];
                    blocked     = 1'b1;
                end
            end else begin
                blocked = 1'b1;
            end
        end
        o_retire_en   = retire_en;
        o_branch      = branch_hit;
        o_branch_addr = branch_addr;
    end

    always_comb begin
        logic                 hit;
        logic [TAG_WIDTH-1:0] ltag;
        for (int unsigned l = 0; l < LOOKUPS; l++) begin
            ltag = i_lookup_tag[l*TAG_WIDTH +: TAG_WIDTH];
            hit  = 1'b0;
            o_lookup_data[l*DATA_WIDTH +: DATA_WIDTH] = ent_data[ltag];
            o_lookup_rdy[l]                           = ent_rdy[ltag];
            for (int unsigned p = 0; p < CDB_PORTS; p++) begin
                if (!hit && i_cdb_en[p] && (cdb_idx[p] == ltag)) begin
                    hit = 1'b1;
                    o_lookup_data[l*DATA_WIDTH +: DATA_WIDTH] = i_cdb_data[p*DATA_WIDTH +: DATA_WIDTH];
                    o_lookup_rdy[l]                           = 1'b1;
                end
            end
        end
    end

    always_comb begin
        cdb_dup = 1'b0;
        for (int unsigned p = 0; p < CDB_PORTS; p++) begin
            for (int unsigned q = p + 1; q < CDB_PORTS; q++) begin
                if (i_cdb_en[p] && i_cdb_en[q] && (cdb_idx[p] == cdb_idx[q])) begin
                    cdb_dup = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            assert (!cdb_dup);
        end
    end

    // A retiring branch discards every younger entry and this cycle's writes.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            head       <= '0;
            tail       <= '0;
            ent_valid  <= '0;
            ent_rdy    <= '0;
            ent_branch <= '0;
        end else if (branch_hit) begin
            head      <= head + retire_cnt;
            tail      <= head + retire_cnt;
            ent_valid <= '0;
        end else begin
            for (int unsigned k = 0; k < DISPATCH_WIDTH; k++) begin
                if (disp_fire && i_disp_valid[k]) begin
                    ent_valid[disp_idx[k]]  <= 1'b1;
                    ent_rdy[disp_idx[k]]    <= i_disp_rdy[k];
                    ent_branch[disp_idx[k]] <= 1'b0;
                end
            end
            for (int unsigned p = 0; p < CDB_PORTS; p++) begin
                if (i_cdb_en[p] && ent_valid[cdb_idx[p]]) begin
                    ent_rdy[cdb_idx[p]]    <= 1'b1;
                    ent_branch[cdb_idx[p]] <= i_cdb_branch[p];
                end
            end
            for (int unsigned j = 0; j < RETIRE_WIDTH; j++) begin
                if (retire_en[j]) begin
                    ent_valid[ret_idx[j]] <= 1'b0;
                end
            end
            head <= head + retire_cnt;
            if (disp_fire) begin
                tail <= tail + alloc_cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < DISPATCH_WIDTH; k++) begin
            if (disp_fire && i_disp_valid[k]) begin
                ent_data[disp_idx[k]]  <= i_disp_data[k*DATA_WIDTH +: DATA_WIDTH];
                ent_rdest[disp_idx[k]] <= i_disp_rdest[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            end
        end
        for (int unsigned p = 0; p < CDB_PORTS; p++) begin
            if (!branch_hit && i_cdb_en[p] && ent_valid[cdb_idx[p]]) begin
                ent_data[cdb_idx[p]] <= i_cdb_data[p*DATA_WIDTH +: DATA_WIDTH];
                ent_addr[cdb_idx[p]] <= i_cdb_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer_mw.sv
// Bench for reorder_buffer_mw: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_reorder_buffer_mw;

    localparam int DW    = 2;
    localparam int RW    = 2;
    localparam int CP    = 2;
    localparam int DEPTH = 64;
    localparam int TW    = 6;
    localparam int XW    = 32;
    localparam int AW    = 32;
    localparam int RAW   = 5;
    localparam int LK    = 2 * DW;

    logic              clk;
    logic              n_rst;
    logic [DW-1:0]     i_disp_valid;
    logic [DW-1:0]     i_disp_rdy;
    logic [DW*XW-1:0]  i_disp_data;
    logic [DW*RAW-1:0] i_disp_rdest;
    logic              o_disp_ready;
    logic [DW*TW-1:0]  o_disp_tag;
    logic [CP-1:0]     i_cdb_en;
    logic [CP*TW-1:0]  i_cdb_tag;
    logic [CP*XW-1:0]  i_cdb_data;
    logic [CP*AW-1:0]  i_cdb_addr;
    logic [CP-1:0]     i_cdb_branch;
    logic [LK*TW-1:0]  i_lookup_tag;
    logic [LK*XW-1:0]  o_lookup_data;
    logic [LK-1:0]     o_lookup_rdy;
    logic [RW-1:0]     o_retire_en;
    logic [RW*RAW-1:0] o_retire_rdest;
    logic [RW*XW-1:0]  o_retire_data;
    logic [RW*TW-1:0]  o_retire_tag;
    logic              o_branch;
    logic [AW-1:0]     o_branch_addr;
    logic [TW:0]       o_count;

    reorder_buffer_mw #(
        .DATA_WIDTH(XW), .ADDR_WIDTH(AW), .ROB_DEPTH(DEPTH), .REG_ADDR_WIDTH(RAW),
        .DISPATCH_WIDTH(DW), .RETIRE_WIDTH(RW), .CDB_PORTS(CP)
    ) dut (
        .clk(clk), .n_rst(n_rst),
        .i_disp_valid(i_disp_valid), .i_disp_rdy(i_disp_rdy), .i_disp_data(i_disp_data),
        .i_disp_rdest(i_disp_rdest), .o_disp_ready(o_disp_ready), .o_disp_tag(o_disp_tag),
        .i_cdb_en(i_cdb_en), .i_cdb_tag(i_cdb_tag), .i_cdb_data(i_cdb_data),
        .i_cdb_addr(i_cdb_addr), .i_cdb_branch(i_cdb_branch),
        .i_lookup_tag(i_lookup_tag), .o_lookup_data(o_lookup_data), .o_lookup_rdy(o_lookup_rdy),
        .o_retire_en(o_retire_en), .o_retire_rdest(o_retire_rdest), .o_retire_data(o_retire_data),
        .o_retire_tag(o_retire_tag), .o_branch(o_branch), .o_branch_addr(o_branch_addr),
        .o_count(o_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic           rdy;
        logic           br;
        logic [XW-1:0]  data;
        logic [AW-1:0]  addr;
        logic [RAW-1:0] rdest;
    } ent_t;

    ent_t q[$];
    int   head_ptr = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [TW-1:0] dtag(input int k);
        return o_disp_tag[k*TW +: TW];
    endfunction
    function automatic logic [TW-1:0] rtag(input int j);
        return o_retire_tag[j*TW +: TW];
    endfunction
    function automatic logic [XW-1:0] rdata(input int j);
        return o_retire_data[j*XW +: XW];
    endfunction
    function automatic logic [RAW-1:0] rrd(input int j);
        return o_retire_rdest[j*RAW +: RAW];
    endfunction
    function automatic logic [XW-1:0] ldata(input int l);
        return o_lookup_data[l*XW +: XW];
    endfunction

    // Reference model: the ROB is an ordered queue of live entries from head.
    task automatic model_cycle();
        int             sz;
        int             nret;
        int             off;
        logic           ebr;
        logic           stop;
        logic           erdy;
        logic           hit;
        logic [AW-1:0]  eaddr;
        logic [RW-1:0]  een;
        logic [TW-1:0]  t;
        ent_t           e;
        if (!n_rst) begin
            q.delete();
            head_ptr = 0;
            chk("rst_count", o_count, 0);
            chk("rst_retire_en", o_retire_en, 0);
            chk("rst_branch", o_branch, 0);
            chk("rst_disp_ready", o_disp_ready, 1);
            return;
        end
        sz = q.size(); nret = 0; ebr = 1'b0; eaddr = '0; een = '0; stop = 1'b0;
        for (int j = 0; j < RW; j++) begin
            if (!stop && j < sz) begin
                e = q[j];
                if (e.rdy) begin
                    een[j] = 1'b1;
                    nret++;
                    chk("ret_rdest", rrd(j), e.rdest);
                    chk("ret_data", rdata(j), e.data);
                    chk("ret_tag", rtag(j), (head_ptr + j) % DEPTH);
                    if (e.br) begin
                        ebr = 1'b1; eaddr = e.addr; stop = 1'b1;
                    end
                end else stop = 1'b1;
            end else stop = 1'b1;
        end
        chk("retire_en", o_retire_en, een);
        chk("branch", o_branch, ebr);
        if (ebr) chk("branch_addr", o_branch_addr, eaddr);
        chk("count", o_count, sz);
        erdy = ((DEPTH - sz) >= DW) && !ebr;
        chk("disp_ready", o_disp_ready, erdy);
        for (int k = 0; k < DW; k++) chk("disp_tag", dtag(k), (head_ptr + sz + k) % DEPTH);
        for (int l = 0; l < LK; l++) begin
            t = i_lookup_tag[l*TW +: TW];
            hit = 1'b0;
            for (int p = 0; p < CP; p++) begin
                if (!hit && i_cdb_en[p] && i_cdb_tag[p*TW +: TW] == t) begin
                    hit = 1'b1;
                    chk("lookup_fwd_data", ldata(l), i_cdb_data[p*XW +: XW]);
                    chk("lookup_fwd_rdy", o_lookup_rdy[l], 1);
                end
            end
            off = (int'(t) - (head_ptr % DEPTH) + DEPTH) % DEPTH;
            if (!hit && off < sz) begin
                e = q[off];
                chk("lookup_data", ldata(l), e.data);
                chk("lookup_rdy", o_lookup_rdy[l], e.rdy);
            end
        end
        if (ebr) begin
            q.delete();
        end else begin
            for (int p = 0; p < CP; p++) begin
                if (i_cdb_en[p]) begin
                    off = (int'(i_cdb_tag[p*TW +: TW]) - (head_ptr % DEPTH) + DEPTH) % DEPTH;
                    if (off < sz) begin
                        e = q[off];
                        e.rdy  = 1'b1;
                        e.br   = i_cdb_branch[p];
                        e.data = i_cdb_data[p*XW +: XW];
                        e.addr = i_cdb_addr[p*AW +: AW];
                        q[off] = e;
                    end
                end
            end
            for (int j = 0; j < nret; j++) void'(q.pop_front());
            if (erdy) begin
                for (int k = 0; k < DW; k++) begin
                    if (i_disp_valid[k]) begin
                        e.rdy   = i_disp_rdy[k];
                        e.br    = 1'b0;
                        e.data  = i_disp_data[k*XW +: XW];
                        e.addr  = '0;
                        e.rdest = i_disp_rdest[k*RAW +: RAW];
                        q.push_back(e);
                    end
                end
            end
        end
        head_ptr = (head_ptr + nret) % (2 * DEPTH);
    endtask

    always begin
        @(negedge clk);
        #3;
        model_cycle();
    end

    task automatic idle();
        i_disp_valid = '0; i_disp_rdy = '0; i_disp_data = '0; i_disp_rdest = '0;
        i_cdb_en = '0; i_cdb_tag = '0; i_cdb_data = '0; i_cdb_addr = '0; i_cdb_branch = '0;
        i_lookup_tag = '0;
    endtask

    task automatic step();
        @(negedge clk);
        idle();
    endtask

    task automatic disp(input int lane, input logic rdy, input logic [RAW-1:0] rd, input logic [XW-1:0] d);
        i_disp_valid[lane]              = 1'b1;
        i_disp_rdy[lane]                = rdy;
        i_disp_rdest[lane*RAW +: RAW]   = rd;
        i_disp_data[lane*XW +: XW]      = d;
    endtask

    task automatic cdb(input int p, input logic [TW-1:0] tag, input logic [XW-1:0] d,
                       input logic [AW-1:0] a, input logic br);
        i_cdb_en[p]              = 1'b1;
        i_cdb_tag[p*TW +: TW]    = tag;
        i_cdb_data[p*XW +: XW]   = d;
        i_cdb_addr[p*AW +: AW]   = a;
        i_cdb_branch[p]          = br;
    endtask

    task automatic look(input int l, input logic [TW-1:0] tag);
        i_lookup_tag[l*TW +: TW] = tag;
    endtask

    // Complete up to two not-yet-ready live entries, oldest first.
    task automatic complete_pending(input logic allow_br, input logic rand_en);
        int   p;
        ent_t e;
        p = 0;
        for (int i = 0; i < q.size() && p < CP; i++) begin
            e = q[i];
            if (!e.rdy) begin
                if (!rand_en || $urandom_range(0, 3) != 0) begin
                    cdb(p, TW'((head_ptr + i) % DEPTH), $urandom, $urandom,
                        allow_br && ($urandom_range(0, 7) == 0));
                    if (p == 0) look(0, TW'((head_ptr + i) % DEPTH));
                end
                p++;
            end
        end
    endtask

    initial begin
        int nl;
        n_rst = 1'b0;
        idle();
        step(); step();
        #2;
        chk("L_rst_ready", o_disp_ready, 1);
        chk("L_rst_count", o_count, 0);
        chk("L_rst_retire_en", o_retire_en, 0);
        chk("L_rst_branch", o_branch, 0);
        step(); n_rst = 1'b1;

        // Two-wide dispatch of ready entries retires together next cycle.
        step(); disp(0, 1'b1, 5'd3, 32'hA); disp(1, 1'b1, 5'd4, 32'hB); #2;
        chk("L_tag0", dtag(0), 0);
        chk("L_tag1", dtag(1), 1);
        chk("L_ready", o_disp_ready, 1);
        step(); #2;
        chk("L_count2", o_count, 2);
        chk("L_ret_en11", o_retire_en, 2'b11);
        chk("L_ret_rd0", rrd(0), 3);
        chk("L_ret_rd1", rrd(1), 4);
        chk("L_ret_d0", rdata(0), 32'hA);
        chk("L_ret_d1", rdata(1), 32'hB);
        step(); #2;
        chk("L_count0", o_count, 0);

        // Tags 2..5 not ready; then CDB forward on lookup with concurrent dispatch.
        step(); disp(0, 1'b0, 5'd1, 32'h20); disp(1, 1'b0, 5'd2, 32'h30);
        step(); disp(0, 1'b0, 5'd5, 32'h40); disp(1, 1'b0, 5'd6, 32'h50);
        step(); cdb(0, 6'd5, 32'h55, 32'h0, 1'b0); look(0, 6'd5);
        disp(0, 1'b0, 5'd7, 32'h66); disp(1, 1'b0, 5'd8, 32'h77); #2;
        chk("L_fwd_data", ldata(0), 32'h55);
        chk("L_fwd_rdy", o_lookup_rdy[0], 1);
        chk("L_tag6", dtag(0), 6);
        chk("L_count4", o_count, 4);
        step(); look(0, 6'd6); look(1, 6'd5); #2;
        chk("L_lk6_data", ldata(0), 32'h66);
        chk("L_lk6_rdy", o_lookup_rdy[0], 0);
        chk("L_lk5_data", ldata(1), 32'h55);
        chk("L_lk5_rdy", o_lookup_rdy[1], 1);
        chk("L_count6", o_count, 6);

        // Gap in readiness stops retire at the first not-ready entry.
        step(); cdb(0, 6'd2, 32'h22, 32'h0, 1'b0); cdb(1, 6'd4, 32'h44, 32'h0, 1'b0); #2;
        chk("L_gap_none", o_retire_en, 2'b00);
        step(); #2;
        chk("L_gap_one", o_retire_en, 2'b01);
        chk("L_gap_tag", rtag(0), 2);
        chk("L_gap_data", rdata(0), 32'h22);
        step(); cdb(0, 6'd3, 32'h33, 32'h0, 1'b0); #2;
        chk("L_gap_wait", o_retire_en, 2'b00);
        chk("L_count5", o_count, 5);
        step(); #2;
        chk("L_fill_two", o_retire_en, 2'b11);
        chk("L_fill_tag1", rtag(1), 4);
        chk("L_fill_data1", rdata(1), 32'h44);
        step(); #2;
        chk("L_tag5_ret", o_retire_en, 2'b01);
        chk("L_tag5_data", rdata(0), 32'h55);
        step(); #2;
        chk("L_count2b", o_count, 2);

        // Retiring branch in lane 1 flushes younger entries and this cycle's writes.
        step(); disp(0, 1'b0, 5'd9, 32'h80); disp(1, 1'b0, 5'd10, 32'h90);
        step(); disp(0, 1'b0, 5'd11, 32'hA0); disp(1, 1'b0, 5'd12, 32'hB0);
        step(); cdb(0, 6'd6, 32'h60, 32'h0, 1'b0); cdb(1, 6'd7, 32'h70, 32'h400, 1'b1); #2;
        chk("L_br_pre", o_retire_en, 2'b00);
        step(); cdb(0, 6'd9, 32'h99, 32'h0, 1'b0);
        disp(0, 1'b1, 5'd1, 32'h1); disp(1, 1'b1, 5'd2, 32'h2); #2;
        chk("L_br_en", o_retire_en, 2'b11);
        chk("L_br", o_branch, 1);
        chk("L_br_addr", o_branch_addr, 32'h400);
        chk("L_br_link", rdata(1), 32'h70);
        chk("L_br_noready", o_disp_ready, 0);
        step(); look(0, 6'd9); #2;
        chk("L_post_count", o_count, 0);
        chk("L_post_branch", o_branch, 0);
        chk("L_post_ready", o_disp_ready, 1);
        chk("L_post_tag", dtag(0), 8);
        chk("L_post_cdb_drop", o_lookup_rdy[0], 0);

        // Fill to 63, check backpressure across a single retire, then fill to 64.
        for (int c = 0; c < 31; c++) begin
            step(); disp(0, 1'b0, 5'd1, XW'(c)); disp(1, 1'b0, 5'd2, XW'(c + 100));
        end
        step(); disp(0, 1'b0, 5'd3, 32'h300);
        step(); disp(0, 1'b1, 5'd4, 32'h1); disp(1, 1'b1, 5'd4, 32'h2);
        cdb(0, 6'd8, 32'h88, 32'h0, 1'b0); #2;
        chk("L_full63", o_count, 63);
        chk("L_full_ready", o_disp_ready, 0);
        step(); #2;
        chk("L_full_ret", o_retire_en, 2'b01);
        chk("L_full_ready2", o_disp_ready, 0);
        step(); disp(0, 1'b0, 5'd5, 32'h5); disp(1, 1'b0, 5'd6, 32'h6); #2;
        chk("L_62", o_count, 62);
        chk("L_62_ready", o_disp_ready, 1);
        step(); #2;
        chk("L_64", o_count, 64);
        chk("L_64_ready", o_disp_ready, 0);

        // Long mixed run wraps the tags; reset lands mid-stream.
        for (int c = 0; c < 200; c++) begin
            step();
            n_rst = (c != 120);
            nl = $urandom_range(0, 2);
            for (int k = 0; k < nl; k++) begin
                disp(k, 1'($urandom_range(0, 1)), RAW'($urandom_range(0, 31)), $urandom);
            end
            for (int l = 1; l < LK; l++) look(l, TW'($urandom_range(0, DEPTH - 1)));
            complete_pending(1'b1, 1'b1);
            if (c == 120) begin
                #2;
                chk("L_midrst_count", o_count, 0);
                chk("L_midrst_en", o_retire_en, 0);
                chk("L_midrst_ready", o_disp_ready, 1);
            end
        end

        for (int c = 0; c < 40; c++) begin
            step();
            complete_pending(1'b0, 1'b0);
        end
        step(); #2;
        chk("L_drained", o_count, 0);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
